decode_select_arbiter: RTL and testbench

- Round-robin arbiter that shares one bus resource between four requesters.
- Its outputs drive a dual-2→4-decoder chip-select path: SEL[1:0] feeds the decoder address, N_EN feeds the decoder's active-low enable.
- It also presents the decoded active-low grant (N_GNT) directly, so the arbiter and the discrete-decoder implementation can be checked against each other.
- Sits between the bus masters and the 74-series select logic.

---
 rtl/decode_select_arbiter.sv | 148 ++++++++++++++
 tb/tb_decode_select_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_select_arbiter.sv
// Round-robin arbiter for four bus masters driving a 2->4 decoder chip-select path.
// SEL/N_EN feed the external decoder; N_GNT is the same decode presented directly.
module decode_select_arbiter #(
  parameter int unsigned MAX_HOLD   = 8,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic       CLK,
  input  logic       N_RST,
  input  logic [3:0] REQ,
  output logic [1:0] SEL,
  output logic       N_EN,
  output logic [3:0] N_GNT,
  output logic       BUSY,
  output logic [1:0] STATE_DBG
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);

  // Handshake: REQ is level-held; a grant lasts while REQ[SEL] stays high,
  // and is visible (N_EN low) one cycle after REQ is sampled in IDLE.
  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic       n_en_q, n_en_d;
  logic [3:0] n_gnt_q, n_gnt_d;
  logic       busy_q, busy_d;
  logic [1:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] turn_q, turn_d;

  logic [1:0] win;
  logic       win_vld;
  logic [1:0] scan_idx;
  logic [3:0] others;
  logic       release_req;
  logic       preempt;

  // Scan from furthest to nearest so the requester just after LAST wins.
  always_comb begin
    win      = '0;
    win_vld  = 1'b0;
    scan_idx = '0;
    for (int i = 4; i >= 1; i--) begin
      scan_idx = last_q + 2'(i);
      if (REQ[scan_idx]) begin
        win     = scan_idx;
        win_vld = 1'b1;
      end
    end
  end

  assign others      = REQ & ~(4'b0001 << sel_q);
  assign release_req = ~REQ[sel_q];
  assign preempt     = (hold_q == HOLD_MAX) && (|others);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    n_en_d  = n_en_q;
    n_gnt_d = n_gnt_q;
    busy_d  = busy_q;
    last_d  = last_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_GRANT;
          sel_d   = win;
          n_en_d  = 1'b0;
          n_gnt_d = ~(4'b0001 << win);
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      S_GRANT: begin
        if (release_req || preempt) begin
          state_d = S_TURN;
          n_en_d  = 1'b1;
          n_gnt_d = 4'b1111;
          last_d  = sel_q;
          turn_d  = '0;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 8'd1;
        end
      end
      S_TURN: begin
        if (turn_q == TURN_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          turn_d = turn_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        n_en_d  = 1'b1;
        n_gnt_d = 4'b1111;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_q <= S_IDLE;
      sel_q   <= 2'd0;
      n_en_q  <= 1'b1;
      n_gnt_q <= 4'b1111;
      busy_q  <= 1'b0;
      last_q  <= 2'd3;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      n_en_q  <= n_en_d;
      n_gnt_q <= n_gnt_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  assign SEL       = sel_q;
  assign N_EN      = n_en_q;
  assign N_GNT     = n_gnt_q;
  assign BUSY      = busy_q;
  assign STATE_DBG = state_q;

`ifdef FORMAL
  a_decode: assert property (@(posedge CLK)
    N_GNT == (N_EN ? 4'b1111 : ~(4'b0001 << SEL)));
  a_en_only_grant: assert property (@(posedge CLK)
    (state_q != S_GRANT) |-> N_EN);
  a_hold_range: assert property (@(posedge CLK) hold_q < 8'(MAX_HOLD));
  a_reset_vals: assert property (@(posedge CLK)
    !N_RST |-> (SEL == 2'd0 && N_EN && N_GNT == 4'b1111 && !BUSY));
`endif

endmodule

// File: tb/tb_decode_select_arbiter.sv
// Directed and random bench for decode_select_arbiter against a tenure-level
// reference model (owner / cycles served / dead cycles remaining).
module tb_decode_select_arbiter;

  localparam int MAX_HOLD   = 8;
  localparam int TURNAROUND = 1;

  logic       CLK;
  logic       N_RST;
  logic [3:0] REQ;
  logic [1:0] SEL;
  logic       N_EN;
  logic [3:0] N_GNT;
  logic       BUSY;
  logic [1:0] STATE_DBG;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];

  // Reference model state
  int m_owner;
  int m_served;
  int m_gap;
  int m_last;
  int m_sel;

  decode_select_arbiter #(
    .MAX_HOLD  (MAX_HOLD),
    .TURNAROUND(TURNAROUND)
  ) dut (
    .CLK      (CLK),
    .N_RST    (N_RST),
    .REQ      (REQ),
    .SEL      (SEL),
    .N_EN     (N_EN),
    .N_GNT    (N_GNT),
    .BUSY     (BUSY),
    .STATE_DBG(STATE_DBG)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_owner  = -1;
    m_served = 0;
    m_gap    = 0;
    m_last   = 3;
    m_sel    = 0;
    exp_q.delete();
  endfunction

  task automatic model_step(input logic [3:0] r);
    logic [3:0] gnt;
    bit         waiting;
    waiting = 1'b0;
    if (m_owner >= 0) begin
      for (int k = 0; k < 4; k++)
        if (k != m_owner && r[k]) waiting = 1'b1;
      if (!r[m_owner] || (m_served >= MAX_HOLD - 1 && waiting)) begin
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = TURNAROUND;
      end else begin
        m_served++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (r != 4'd0) begin
      for (int k = 1; k <= 4; k++) begin
        if (m_owner < 0 && r[(m_last + k) % 4]) begin
          m_owner  = (m_last + k) % 4;
          m_sel    = m_owner;
          m_served = 0;
        end
      end
    end
    gnt = 4'b1111;
    if (m_owner >= 0) gnt[m_owner] = 1'b0;
    exp_q.push_back(gnt);
  endtask

  task automatic check_all();
    logic [3:0] exp_gnt;
    logic [3:0] dec;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    exp_gnt = exp_q.pop_front();
    check("n_gnt", N_GNT, exp_gnt);
    check("sel", SEL, m_sel);
    check("n_en", N_EN, (m_owner < 0));
    check("busy", BUSY, (m_owner >= 0 || m_gap > 0));
    dec = 4'b1111;
    if (!N_EN) dec[SEL] = 1'b0;
    check("decoder", N_GNT, dec);
    check("one_low", ($countones(~N_GNT) <= 1), 1);
  endtask

  // Driver: present REQ, clock it in, advance model, sample 1 time unit later.
  task automatic cycle(input logic [3:0] r);
    REQ = r;
    @(posedge CLK);
    model_step(r);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    N_RST = 1'b0;
    REQ   = 4'd0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_sel", SEL, 0);
    check("rst_n_en", N_EN, 1);
    check("rst_n_gnt", N_GNT, 4'b1111);
    check("rst_busy", BUSY, 0);
    #2;
    N_RST = 1'b1;
    model_reset();
  endtask

  initial begin
    int starts[$];
    int lens[$];
    int gaps[$];
    int run;
    int gap;
    bit in_g;
    bit seen;
    int ok;
    logic [3:0] r;

    N_RST = 1'b0;
    REQ   = 4'd0;
    model_reset();

    // Single requester 2: grant, hold, release, turnaround
    do_reset();
    cycle(4'b0100);
    check("t1_sel", SEL, 2);
    check("t1_n_en", N_EN, 0);
    check("t1_n_gnt", N_GNT, 4'b1011);
    check("t1_busy", BUSY, 1);
    repeat (5) cycle(4'b0100);
    check("t1_held", N_GNT, 4'b1011);
    cycle(4'b0000);
    check("t2_turn_gnt", N_GNT, 4'b1111);
    check("t2_turn_busy", BUSY, 1);
    cycle(4'b0000);
    check("t2_idle_busy", BUSY, 0);

    // All four requesting: order 0,1,2,3,0, tenure MAX_HOLD, gap TURNAROUND+1
    do_reset();
    run = 0; gap = 0; in_g = 0; seen = 0;
    for (int c = 0; c < 50; c++) begin
      cycle(4'b1111);
      if (!N_EN) begin
        if (!in_g) begin
          starts.push_back(int'(SEL));
          if (seen) gaps.push_back(gap);
        end
        in_g = 1;
        run++;
      end else begin
        if (in_g) begin
          lens.push_back(run);
          run  = 0;
          seen = 1;
          gap  = 0;
        end
        in_g = 0;
        gap++;
      end
    end
    check("rr_nstarts", (starts.size() >= 5), 1);
    for (int i = 0; i < 5; i++)
      check("rr_order", (i < starts.size()) ? starts[i] : -1, i % 4);
    for (int i = 0; i < 4; i++) begin
      check("rr_tenure", (i < lens.size()) ? lens[i] : -1, MAX_HOLD);
      check("rr_gap", (i < gaps.size()) ? gaps[i] : -1, TURNAROUND + 1);
    end

    // Lone requester 1 is never preempted
    do_reset();
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      cycle(4'b0010);
      if (N_GNT === 4'b1101) ok++;
    end
    check("lone_unbroken", ok, 40);

    // Asynchronous reset mid-grant to requester 3
    do_reset();
    cycle(4'b1000);
    check("ar_sel3", SEL, 3);
    repeat (3) cycle(4'b1001);
    #3;
    N_RST = 1'b0;
    #1;
    check("ar_n_gnt", N_GNT, 4'b1111);
    check("ar_n_en", N_EN, 1);
    check("ar_busy", BUSY, 0);
    check("ar_sel", SEL, 0);
    #2;
    N_RST = 1'b1;
    model_reset();
    cycle(4'b1001);
    check("ar_first_win", SEL, 0);
    check("ar_first_gnt", N_GNT, 4'b1110);

    // Random stimulus with held-ish requests
    do_reset();
    r = 4'd0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      cycle(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
